// File: rtl/rv32_dmem_target_if.sv
// rtl/rv32_dmem_target_if.sv - load/store request/response bundle between the memory stage and the data memory
//
// Signals:
//   req_valid/req_ready    request handshake (initiator -> target)
//   req_write              1 = store, 0 = load
//   req_addr               byte address, bits [1:0] ignored
//   req_wdata/req_wstrb    store data and byte enables
//   resp_valid/resp_ready  response handshake (target -> initiator)
//   resp_rdata             load data, 0 for stores and errors
//   resp_error             request addressed a word outside the RAM
interface rv32_dmem_target_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/rv32_dmem_target.sv
// rtl/rv32_dmem_target.sv - single-outstanding data-memory responder with byte-masked stores and programmable wait
//
// Ports:
//   clk      clock, all state on posedge
//   reset_n  synchronous active-low reset (RAM contents are not reset)
//   bus      rv32_dmem_target_if.slave request/response bundle
// Parameters:
//   DEPTH_WORDS  number of 32-bit words, power of two, >= 4
//   LATENCY      wait cycles between acceptance and response valid, 0..15
module rv32_dmem_target #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input logic                clk,
    input logic                reset_n,
    rv32_dmem_target_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_d;
    logic [31:0] rdata_q;
    logic        error_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        in_range;
    logic [31:0] word_idx;
    logic [AW-1:0] ram_idx;

    // The range check uses the whole word index so that high addresses are
    // rejected instead of wrapping onto low RAM words.
    assign word_idx = bus.req_addr >> 2;
    assign in_range = (word_idx < 32'(DEPTH_WORDS));
    assign ram_idx  = word_idx[AW-1:0];

    // Gated by reset_n so a request presented during reset never commits a store.
    assign accept = reset_n && (state == IDLE) && bus.req_valid;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response payload is fixed at acceptance and held until the handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else if (accept) begin
            if (!in_range) begin
                rdata_q <= 32'd0;
                error_q <= 1'b1;
            end else if (bus.req_write) begin
                rdata_q <= 32'd0;
                error_q <= 1'b0;
            end else begin
                rdata_q <= mem[ram_idx];
                error_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && in_range && bus.req_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_wstrb[i]) begin
                    mem[ram_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32_dmem_target.sv
// tb/tb_rv32_dmem_target.sv - self-checking bench for rv32_dmem_target
module tb_rv32_dmem_target;
    logic clk;
    logic reset_n;

    rv32_dmem_target_if bus ();
    rv32_dmem_target_if bus0 ();

    rv32_dmem_target #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    rv32_dmem_target #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    // One complete transaction on the LATENCY=3 target; lat counts cycles from
    // acceptance to the first cycle with resp_valid high (99 = timed out).
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic er, output int lat);
        int n;
        @(negedge clk);
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_wstrb  = s;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.resp_valid) lat = 99;
        rd = bus.resp_rdata;
        er = bus.resp_error;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,          1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF,  1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0,          1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA,  1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,          1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA,  1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0,          1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0,          1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1234_5678,  1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'h0,          1'b1};
        vecs[10] = '{1'b1, 32'h0000_03FF, 32'hA5A5_A5A5, 4'hF, 32'h0,          1'b0};
        vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'hA5A5_A5A5,  1'b0};
        vecs[12] = '{1'b0, 32'h4000_0000, 32'h0,         4'h0, 32'h0,          1'b1};
        vecs[13] = '{1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0,          1'b1};
        vecs[14] = '{1'b1, 32'h0000_0012, 32'h00CC_0000, 4'h4, 32'h0,          1'b0};
        vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDECC_BEAA,  1'b0};

        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = 32'h0;
        bus.req_wdata   = 32'h0;
        bus.req_wstrb   = 4'h0;
        bus.resp_ready  = 1'b0;
        bus0.req_valid  = 1'b0;
        bus0.req_write  = 1'b0;
        bus0.req_addr   = 32'h0;
        bus0.req_wdata  = 32'h0;
        bus0.req_wstrb  = 4'h0;
        bus0.resp_ready = 1'b1;
        reset_n         = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_req_ready",  32'(bus.req_ready),  32'h1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("reset_resp_rdata", bus.resp_rdata,      32'h0);
        chk("reset_resp_error", 32'(bus.resp_error), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            xact(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end

        // Cycle-exact timing: accept cycle, then 3 WAIT cycles and RESP.
        @(negedge clk);
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        chk("timing_accept_ready", 32'(bus.req_ready), 32'h1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk($sformatf("timing_c%0d_req_ready", c), 32'(bus.req_ready), 32'h0);
            chk($sformatf("timing_c%0d_resp_valid", c), 32'(bus.resp_valid), 32'(c == 4));
        end
        @(negedge clk);
        chk("timing_ready_after_hs", 32'(bus.req_ready), 32'h1);

        // Back-pressure: held request, response stalled for 10 cycles.
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_resp_seen", 32'(bus.resp_valid), 32'h1);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall%0d_resp_valid", c), 32'(bus.resp_valid), 32'h1);
            chk($sformatf("stall%0d_req_ready", c), 32'(bus.req_ready), 32'h0);
            chk($sformatf("stall%0d_rdata", c), bus.resp_rdata, 32'h1234_5678);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("stall_ready_after_hs", 32'(bus.req_ready), 32'h1);
        chk("stall_valid_after_hs", 32'(bus.resp_valid), 32'h0);

        // Reset during WAIT after a store.
        bus.req_write  = 1'b1;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'hCAFE_F00D;
        bus.req_wstrb  = 4'hF;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_wait_state", 32'(bus.req_ready), 32'h0);
        reset_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d_resp_valid", c), 32'(bus.resp_valid), 32'h0);
        end
        reset_n = 1'b1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d_resp_valid", c), 32'(bus.resp_valid), 32'h0);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("rst_store_kept", rd, 32'hCAFE_F00D);
        chk("rst_store_kept_err", 32'(er), 32'h0);

        // LATENCY = 0 target: response in the cycle right after acceptance.
        @(negedge clk);
        bus0.req_write = 1'b1;
        bus0.req_addr  = 32'h8;
        bus0.req_wdata = 32'h1122_3344;
        bus0.req_wstrb = 4'hF;
        bus0.req_valid = 1'b1;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        chk("lat0_store_valid", 32'(bus0.resp_valid), 32'h1);
        chk("lat0_store_ready", 32'(bus0.req_ready), 32'h0);
        chk("lat0_store_rdata", bus0.resp_rdata, 32'h0);
        @(negedge clk);
        chk("lat0_ready_after_hs", 32'(bus0.req_ready), 32'h1);
        bus0.req_write = 1'b0;
        bus0.req_valid = 1'b1;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        chk("lat0_load_valid", 32'(bus0.resp_valid), 32'h1);
        chk("lat0_load_rdata", bus0.resp_rdata, 32'h1122_3344);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rv32_dmem_target.md
# rv32_dmem_target

Data-memory responder for the rv32 pipeline: the target end of the load/store interface that the memory stage drives. It accepts one word-addressed request at a time over a valid/ready handshake, performs a byte-masked write or a word read against an internal RAM after a programmable wait, and returns a single response per request. Out-of-range addresses are rejected with an error response and never corrupt storage.

## Interface

- DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
- LATENCY, 1, wait cycles between request acceptance and response valid; range 0–15.

- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  target can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] ignored, word index = req_addr[31:2].
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte enables for stores; bit i enables wdata[8i+7:8i]; ignored for loads.
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_error  output  1  request addressed a word index ≥ DEPTH_WORDS.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready: latch req_write, compute in_range = (req_addr[31:2] < DEPTH_WORDS).
  - Store, in range: write enabled bytes on the acceptance edge; other bytes unchanged.
  - Load, in range: capture the addressed word into the response register on the acceptance edge.
  - Out of range: no RAM access; response register = 0, error flag = 1.
  - Next state WAIT with wait counter = LATENCY, or RESP directly when LATENCY = 0.
- WAIT: req_ready = 0; counter decrements each cycle; on the cycle it reaches 1, next state RESP.
- RESP: resp_valid = 1, resp_rdata and resp_error stable until handshake. On resp_valid && resp_ready, next state IDLE.
- req_ready is low in WAIT and RESP; requests presented then are not accepted and must be held by the initiator.
- Exactly one response per accepted request, in order.
- Store with req_wstrb = 0: legal; no bytes change; normal response.
- Load data is the RAM contents at the acceptance edge, excluding the store accepted on the same edge, because a single request is in flight.
- Address arithmetic: comparison on the full 30-bit word index, so addresses that would alias after truncation are rejected, not wrapped.

## Timing

- Reset values (reset_n low at a posedge): state = IDLE, req_ready = 1 from the next cycle, resp_valid = 0, resp_rdata = 0, resp_error = 0, wait counter = 0. RAM contents are not reset.
- Reset mid-operation (in WAIT or RESP): the pending response is discarded. A store committed at acceptance remains committed.
- Acceptance at edge T. resp_valid is high in the cycle after edge T + LATENCY, i.e. LATENCY+1 cycles after the request cycle.
- A response consumed at edge U gives req_ready = 1 in the cycle after U. Back-to-back throughput is one request per LATENCY+2 cycles when resp_ready is held high.
- resp_ready held low: the target stays in RESP indefinitely with outputs frozen.
- req_ready is a registered state decode only; it has no combinational path from req_valid or resp_ready.

## Test plan

- Reset, then store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, followed by a load from 0x10. Required: the store response has rdata 0 and error 0, and the load returns 0xDEADBEEF.
- Partial store to addr 0x10 with wdata 0x000000AA, wstrb 0x1. Required: a load from 0x10 returns 0xDEADBEAA; from the preceding state a further store with wstrb 0x0 leaves the word unchanged.
- LATENCY = 3, load accepted at cycle 5. Required: resp_valid first high at cycle 9, and req_ready low during cycles 6–9.
- resp_ready held low for 10 cycles in RESP while req_valid stays high. Required: no second acceptance, rdata stable, and req_ready high the cycle after the handshake.
- Store to word index DEPTH_WORDS (addr 0x400 with default DEPTH_WORDS) with wstrb 0xF. Required: resp_error = 1, and a load from 0x0 still returns its prior value.
- Assert reset_n low during WAIT after a store to 0x20. Required: resp_valid never rises, req_ready is 1 after reset, and a load from 0x20 returns the stored data.
